// File: rtl/systolic_ctrl.sv
// Command sequencer for the 2x2 weight-stationary systolic array: weight load, switch, skewed input stream, drain.
// Define SYSTOLIC_CTRL_TIMEOUT_EN to add the drain watchdog that raises err.
module systolic_ctrl #(
  parameter int WIDTH         = 2,
  parameter int DATA_W        = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_rows,
  input  logic [1:0]        cmd_cols,
  input  logic              cmd_skip_w,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data_1,
  input  logic [DATA_W-1:0] w_data_2,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data_1,
  input  logic [DATA_W-1:0] x_data_2,
  output logic [DATA_W-1:0] sys_weight_in_11,
  output logic [DATA_W-1:0] sys_weight_in_12,
  output logic              sys_accept_w_1,
  output logic              sys_accept_w_2,
  output logic              sys_switch_in,
  output logic              sys_start,
  output logic [DATA_W-1:0] sys_data_in_11,
  output logic [DATA_W-1:0] sys_data_in_21,
  output logic [15:0]       ub_rd_col_size_in,
  output logic              ub_rd_col_size_valid_in,
  input  logic              sys_valid_out_21,
  input  logic              sys_valid_out_22,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WB_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WB_W-1:0] WB_LAST = WB_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LOAD_W, S_SWITCH, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       rows_q, rows_d;
  logic [1:0]        cols_q, cols_d;
  logic              skip_q, skip_d;
  logic [WB_W-1:0]   wbeat_q, wbeat_d;
  logic [15:0]       xcnt_q, xcnt_d;
  logic [15:0]       cnt1_q, cnt1_d;
  logic [15:0]       cnt2_q, cnt2_d;
  logic [DATA_W-1:0] w11_q, w11_d, w12_q, w12_d;
  logic              acc1_q, acc1_d, acc2_q, acc2_d;
  logic              sw_q, sw_d, start_q, start_d;
  logic [DATA_W-1:0] d11_q, d11_d, d21_q, d21_d, skew_q, skew_d;
  logic [15:0]       ub_size_q, ub_size_d;
  logic              ub_vld_q, ub_vld_d;

  logic       accept, w_beat, x_beat, two_col;
  logic [1:0] cols_in;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign w_beat  = w_valid && (state_q == S_LOAD_W);
  assign x_beat  = x_valid && (state_q == S_STREAM);
  assign cols_in = (cmd_cols == 2'd1) ? 2'd1 : 2'd2;
  assign two_col = (cols_q == 2'd2);

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(DRAIN_TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            timeout;
`endif

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    skip_d  = skip_q;
    wbeat_d = wbeat_q;
    xcnt_d  = xcnt_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = S_CFG;
        rows_d  = cmd_rows;
        cols_d  = cols_in;
        skip_d  = cmd_skip_w;
      end
      S_CFG: begin
        cnt1_d  = '0;
        cnt2_d  = '0;
        wbeat_d = '0;
        xcnt_d  = '0;
        if (!skip_q)              state_d = S_LOAD_W;
        else if (rows_q == 16'd0) state_d = S_DONE;
        else                      state_d = S_STREAM;
      end
      S_LOAD_W: if (w_valid) begin
        if (wbeat_q == WB_LAST) state_d = S_SWITCH;
        else                    wbeat_d = wbeat_q + WB_W'(1);
      end
      S_SWITCH: state_d = (rows_q == 16'd0) ? S_DONE : S_STREAM;
      S_STREAM: if (x_valid) begin
        xcnt_d = xcnt_q + 16'd1;
        if (xcnt_d == rows_q) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counters saturate at M so surplus array pulses cannot overshoot the exit compare.
    if (state_q == S_STREAM || state_q == S_DRAIN) begin
      if (sys_valid_out_21 && cnt1_q != rows_q) cnt1_d = cnt1_q + 16'd1;
      if (sys_valid_out_22 && cnt2_q != rows_q) cnt2_d = cnt2_q + 16'd1;
    end
    if (state_q == S_DRAIN && cnt1_d == rows_q && (!two_col || cnt2_d == rows_q))
      state_d = S_DONE;

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    wd_d    = '0;
    timeout = 1'b0;
    if (state_q == S_DRAIN && !sys_valid_out_21 && !sys_valid_out_22) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_d == WD_LIM && state_d == S_DRAIN) begin
        timeout = 1'b1;
        state_d = S_DONE;
      end
    end
    err_d = accept ? 1'b0 : (timeout ? 1'b1 : err_q);
`endif
  end

  always_comb begin
    w11_d     = w_beat ? w_data_1 : w11_q;
    w12_d     = (w_beat && two_col) ? w_data_2 : w12_q;
    acc1_d    = w_beat;
    acc2_d    = w_beat && two_col;
    sw_d      = (state_q == S_SWITCH);
    start_d   = x_beat;
    d11_d     = x_beat ? x_data_1 : '0;
    skew_d    = x_beat ? x_data_2 : '0;
    d21_d     = skew_q;
    ub_vld_d  = accept;
    ub_size_d = accept ? {14'd0, cols_in} : 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      skip_q    <= 1'b0;
      wbeat_q   <= '0;
      xcnt_q    <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      w11_q     <= '0;
      w12_q     <= '0;
      acc1_q    <= 1'b0;
      acc2_q    <= 1'b0;
      sw_q      <= 1'b0;
      start_q   <= 1'b0;
      d11_q     <= '0;
      d21_q     <= '0;
      skew_q    <= '0;
      ub_size_q <= '0;
      ub_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      skip_q    <= skip_d;
      wbeat_q   <= wbeat_d;
      xcnt_q    <= xcnt_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      w11_q     <= w11_d;
      w12_q     <= w12_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      sw_q      <= sw_d;
      start_q   <= start_d;
      d11_q     <= d11_d;
      d21_q     <= d21_d;
      skew_q    <= skew_d;
      ub_size_q <= ub_size_d;
      ub_vld_q  <= ub_vld_d;
    end
  end

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (DRAIN_TIMEOUT != 0);
  assign err        = 1'b0;
`endif

  assign cmd_ready               = (state_q == S_IDLE);
  assign busy                    = (state_q != S_IDLE);
  assign done                    = (state_q == S_DONE);
  assign w_ready                 = (state_q == S_LOAD_W);
  assign x_ready                 = (state_q == S_STREAM);
  assign sys_weight_in_11        = w11_q;
  assign sys_weight_in_12        = w12_q;
  assign sys_accept_w_1          = acc1_q;
  assign sys_accept_w_2          = acc2_q;
  assign sys_switch_in           = sw_q;
  assign sys_start               = start_q;
  assign sys_data_in_11          = d11_q;
  assign sys_data_in_21          = d21_q;
  assign ub_rd_col_size_in       = ub_size_q;
  assign ub_rd_col_size_valid_in = ub_vld_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed testbench for systolic_ctrl; each scenario task checks cycle-exact outputs against hand-computed values.
module tb_systolic_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_skip_w;
  logic [15:0]   cmd_rows;
  logic [1:0]    cmd_cols;
  logic          w_valid, w_ready, x_valid, x_ready;
  logic [DW-1:0] w_data_1, w_data_2, x_data_1, x_data_2;
  logic [DW-1:0] sys_weight_in_11, sys_weight_in_12, sys_data_in_11, sys_data_in_21;
  logic          sys_accept_w_1, sys_accept_w_2, sys_switch_in, sys_start;
  logic [15:0]   ub_rd_col_size_in;
  logic          ub_rd_col_size_valid_in;
  logic          sys_valid_out_21, sys_valid_out_22;
  logic          busy, done, err;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int wload_seen = 0;
  int acc2_seen = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.WIDTH(2), .DATA_W(DW), .DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .cmd_cols(cmd_cols), .cmd_skip_w(cmd_skip_w),
    .w_valid(w_valid), .w_ready(w_ready), .w_data_1(w_data_1), .w_data_2(w_data_2),
    .x_valid(x_valid), .x_ready(x_ready), .x_data_1(x_data_1), .x_data_2(x_data_2),
    .sys_weight_in_11(sys_weight_in_11), .sys_weight_in_12(sys_weight_in_12),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in), .sys_start(sys_start),
    .sys_data_in_11(sys_data_in_11), .sys_data_in_21(sys_data_in_21),
    .ub_rd_col_size_in(ub_rd_col_size_in), .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_valid_out_21(sys_valid_out_21), .sys_valid_out_22(sys_valid_out_22),
    .busy(busy), .done(done), .err(err)
  );

  // Mid-cycle activity counters; scenarios compare deltas across a job.
  always @(negedge clk) begin
    if (done) done_seen <= done_seen + 1;
    if (w_ready || sys_accept_w_1 || sys_accept_w_2 || sys_switch_in) wload_seen <= wload_seen + 1;
    if (sys_accept_w_2) acc2_seen <= acc2_seen + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [15:0] r, input logic [1:0] c, input logic s);
    cmd_valid = 1'b1; cmd_rows = r; cmd_cols = c; cmd_skip_w = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Entered in the CFG cycle; returns in the SWITCH cycle.
  task automatic load_w(input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                        input logic [DW-1:0] b1, input logic [DW-1:0] b2);
    tick();
    w_valid = 1'b1; w_data_1 = a1; w_data_2 = a2;
    tick();
    w_data_1 = b1; w_data_2 = b2;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready); end
    total++; if ({busy, done, err, w_ready, x_ready} !== 5'b0) begin bad++; $display("FAIL rst_status got=%b exp=00000", {busy, done, err, w_ready, x_ready}); end
    total++; if ({sys_accept_w_1, sys_accept_w_2, sys_switch_in, sys_start, ub_rd_col_size_valid_in} !== 5'b0) begin bad++; $display("FAIL rst_strobes got=%b exp=00000", {sys_accept_w_1, sys_accept_w_2, sys_switch_in, sys_start, ub_rd_col_size_valid_in}); end
    total++; if ({sys_weight_in_11, sys_weight_in_12, sys_data_in_11, sys_data_in_21, ub_rd_col_size_in} !== 80'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", {sys_weight_in_11, sys_weight_in_12, sys_data_in_11, sys_data_in_21, ub_rd_col_size_in}); end
    rst = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_release got=%0b%0b exp=10", cmd_ready, busy); end
  endtask

  task automatic test_full_job();
    int d0;
    d0 = done_seen;
    issue_cmd(16'd3, 2'd2, 1'b0);
    total++; if (ub_rd_col_size_valid_in !== 1'b1 || ub_rd_col_size_in !== 16'd2) begin bad++; $display("FAIL full_cfg got=%0b/%0d exp=1/2", ub_rd_col_size_valid_in, ub_rd_col_size_in); end
    total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL full_busy got=%0b%0b exp=10", busy, cmd_ready); end
    tick();
    total++; if (ub_rd_col_size_valid_in !== 1'b0 || w_ready !== 1'b1) begin bad++; $display("FAIL full_loadw got=%0b%0b exp=01", ub_rd_col_size_valid_in, w_ready); end
    w_valid = 1'b1; w_data_1 = 16'd5; w_data_2 = 16'd6;
    tick();
    total++; if ({sys_accept_w_1, sys_accept_w_2} !== 2'b11 || sys_weight_in_11 !== 16'd5 || sys_weight_in_12 !== 16'd6) begin bad++; $display("FAIL full_w0 got=%b %0d %0d exp=11 5 6", {sys_accept_w_1, sys_accept_w_2}, sys_weight_in_11, sys_weight_in_12); end
    w_data_1 = 16'd7; w_data_2 = 16'd8;
    tick();
    total++; if (sys_accept_w_1 !== 1'b1 || sys_weight_in_11 !== 16'd7 || sys_weight_in_12 !== 16'd8 || sys_switch_in !== 1'b0) begin bad++; $display("FAIL full_w1 got=%0b %0d %0d sw=%0b exp=1 7 8 sw=0", sys_accept_w_1, sys_weight_in_11, sys_weight_in_12, sys_switch_in); end
    w_valid = 1'b0;
    tick();
    total++; if (sys_switch_in !== 1'b1 || sys_accept_w_1 !== 1'b0 || x_ready !== 1'b1) begin bad++; $display("FAIL full_switch got=sw%0b acc%0b xr%0b exp=sw1 acc0 xr1", sys_switch_in, sys_accept_w_1, x_ready); end
    x_valid = 1'b1; x_data_1 = 16'd11; x_data_2 = 16'd21;
    tick();
    total++; if (sys_start !== 1'b1 || sys_data_in_11 !== 16'd11 || sys_data_in_21 !== 16'd0 || sys_switch_in !== 1'b0) begin bad++; $display("FAIL full_x0 got=%0b %0d %0d sw=%0b exp=1 11 0 sw=0", sys_start, sys_data_in_11, sys_data_in_21, sys_switch_in); end
    x_data_1 = 16'd12; x_data_2 = 16'd22;
    tick();
    total++; if (sys_data_in_11 !== 16'd12 || sys_data_in_21 !== 16'd21) begin bad++; $display("FAIL full_x1 got=%0d %0d exp=12 21", sys_data_in_11, sys_data_in_21); end
    x_data_1 = 16'd13; x_data_2 = 16'd23;
    tick();
    total++; if (sys_data_in_11 !== 16'd13 || sys_data_in_21 !== 16'd22 || x_ready !== 1'b0) begin bad++; $display("FAIL full_x2 got=%0d %0d xr=%0b exp=13 22 xr=0", sys_data_in_11, sys_data_in_21, x_ready); end
    x_valid = 1'b0;
    tick();
    total++; if (sys_start !== 1'b0 || sys_data_in_11 !== 16'd0 || sys_data_in_21 !== 16'd23) begin bad++; $display("FAIL full_flush got=%0b %0d %0d exp=0 0 23", sys_start, sys_data_in_11, sys_data_in_21); end
    for (int p = 0; p < 3; p++) begin
      sys_valid_out_21 = 1'b1; sys_valid_out_22 = 1'b1;
      tick();
      sys_valid_out_21 = 1'b0; sys_valid_out_22 = 1'b0;
      total++; if (done !== (p == 2)) begin bad++; $display("FAIL full_done_p%0d got=%0b exp=%0b", p, done, (p == 2)); end
      if (p < 2) tick();
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err got=%0b exp=0", err); end
    tick();
    total++; if (done !== 1'b0 || cmd_ready !== 1'b1 || done_seen - d0 != 1) begin bad++; $display("FAIL full_end got=done%0b rdy%0b n%0d exp=done0 rdy1 n1", done, cmd_ready, done_seen - d0); end
  endtask

  task automatic test_cols1();
    int a0;
    a0 = acc2_seen;
    issue_cmd(16'd2, 2'd1, 1'b0);
    total++; if (ub_rd_col_size_in !== 16'd1) begin bad++; $display("FAIL c1_size got=%0d exp=1", ub_rd_col_size_in); end
    load_w(16'd31, 16'd99, 16'd32, 16'd98);
    total++; if (sys_weight_in_11 !== 16'd32 || sys_weight_in_12 !== 16'd8 || sys_accept_w_2 !== 1'b0) begin bad++; $display("FAIL c1_weights got=%0d %0d acc2=%0b exp=32 8 acc2=0", sys_weight_in_11, sys_weight_in_12, sys_accept_w_2); end
    tick();
    x_valid = 1'b1; x_data_1 = 16'd1; x_data_2 = 16'd2;
    tick();
    x_data_1 = 16'd3; x_data_2 = 16'd4;
    tick();
    x_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sys_valid_out_21 = 1'b1;
      tick();
      sys_valid_out_21 = 1'b0;
      total++; if (done !== (p == 1)) begin bad++; $display("FAIL c1_done_p%0d got=%0b exp=%0b", p, done, (p == 1)); end
      if (p < 1) tick();
    end
    tick();
    total++; if (acc2_seen - a0 != 0) begin bad++; $display("FAIL c1_acc2 got=%0d exp=0", acc2_seen - a0); end
  endtask

  task automatic test_stall();
    issue_cmd(16'd4, 2'd2, 1'b0);
    load_w(16'd41, 16'd42, 16'd43, 16'd44);
    tick();
    x_valid = 1'b1; x_data_1 = 16'd1; x_data_2 = 16'd101;
    tick();
    x_data_1 = 16'd2; x_data_2 = 16'd102;
    tick();
    x_valid = 1'b0; x_data_1 = 16'd77; x_data_2 = 16'd77;
    tick();
    total++; if (sys_start !== 1'b0 || sys_data_in_11 !== 16'd0 || sys_data_in_21 !== 16'd102) begin bad++; $display("FAIL st_gap1 got=%0b %0d %0d exp=0 0 102", sys_start, sys_data_in_11, sys_data_in_21); end
    tick();
    total++; if (sys_start !== 1'b0 || sys_data_in_11 !== 16'd0 || sys_data_in_21 !== 16'd0) begin bad++; $display("FAIL st_gap2 got=%0b %0d %0d exp=0 0 0", sys_start, sys_data_in_11, sys_data_in_21); end
    x_valid = 1'b1; x_data_1 = 16'd3; x_data_2 = 16'd103;
    tick();
    total++; if (sys_start !== 1'b1 || sys_data_in_11 !== 16'd3 || sys_data_in_21 !== 16'd0) begin bad++; $display("FAIL st_resume got=%0b %0d %0d exp=1 3 0", sys_start, sys_data_in_11, sys_data_in_21); end
    x_data_1 = 16'd4; x_data_2 = 16'd104;
    tick();
    total++; if (sys_data_in_11 !== 16'd4 || sys_data_in_21 !== 16'd103 || x_ready !== 1'b0) begin bad++; $display("FAIL st_last got=%0d %0d xr=%0b exp=4 103 xr=0", sys_data_in_11, sys_data_in_21, x_ready); end
    x_valid = 1'b0;
    tick();
    total++; if (sys_data_in_21 !== 16'd104) begin bad++; $display("FAIL st_flush got=%0d exp=104", sys_data_in_21); end
    sys_valid_out_21 = 1'b1;
    repeat (5) tick();
    sys_valid_out_21 = 1'b0;
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL st_col2_pending got=done%0b busy%0b exp=done0 busy1", done, busy); end
    for (int p = 0; p < 4; p++) begin
      sys_valid_out_22 = 1'b1;
      tick();
      total++; if (done !== (p == 3)) begin bad++; $display("FAIL st_done_p%0d got=%0b exp=%0b", p, done, (p == 3)); end
    end
    sys_valid_out_22 = 1'b0;
    tick();
    total++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL st_end got=done%0b rdy%0b exp=done0 rdy1", done, cmd_ready); end
  endtask

  task automatic test_skip_w();
    int l0;
    l0 = wload_seen;
    issue_cmd(16'd1, 2'd2, 1'b1);
    total++; if (ub_rd_col_size_valid_in !== 1'b1 || ub_rd_col_size_in !== 16'd2) begin bad++; $display("FAIL sk_cfg got=%0b/%0d exp=1/2", ub_rd_col_size_valid_in, ub_rd_col_size_in); end
    tick();
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL sk_stream got=%0b exp=1", x_ready); end
    x_valid = 1'b1; x_data_1 = 16'd9; x_data_2 = 16'd19;
    tick();
    x_valid = 1'b0;
    total++; if (sys_start !== 1'b1 || sys_data_in_11 !== 16'd9 || x_ready !== 1'b0) begin bad++; $display("FAIL sk_beat got=%0b %0d xr=%0b exp=1 9 xr=0", sys_start, sys_data_in_11, x_ready); end
    tick();
    total++; if (sys_data_in_21 !== 16'd19) begin bad++; $display("FAIL sk_row2 got=%0d exp=19", sys_data_in_21); end
    sys_valid_out_21 = 1'b1; sys_valid_out_22 = 1'b1;
    tick();
    sys_valid_out_21 = 1'b0; sys_valid_out_22 = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sk_done got=%0b exp=1", done); end
    total++; if (wload_seen - l0 != 0 || sys_weight_in_11 !== 16'd43) begin bad++; $display("FAIL sk_noload got=n%0d w%0d exp=n0 w43", wload_seen - l0, sys_weight_in_11); end
    tick();
  endtask

  task automatic test_zero_rows();
    issue_cmd(16'd0, 2'd3, 1'b1);
    total++; if (ub_rd_col_size_in !== 16'd2) begin bad++; $display("FAIL z_clamp3 got=%0d exp=2", ub_rd_col_size_in); end
    tick();
    total++; if (done !== 1'b1 || x_ready !== 1'b0) begin bad++; $display("FAIL z_skip_done got=done%0b xr%0b exp=done1 xr0", done, x_ready); end
    tick();
    issue_cmd(16'd0, 2'd0, 1'b0);
    total++; if (ub_rd_col_size_in !== 16'd2) begin bad++; $display("FAIL z_clamp0 got=%0d exp=2", ub_rd_col_size_in); end
    load_w(16'd1, 16'd2, 16'd3, 16'd4);
    tick();
    total++; if (done !== 1'b1 || sys_switch_in !== 1'b1 || x_ready !== 1'b0) begin bad++; $display("FAIL z_sw_done got=done%0b sw%0b xr%0b exp=done1 sw1 xr0", done, sys_switch_in, x_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_seen;
    issue_cmd(16'd2, 2'd2, 1'b0);
    tick();
    w_valid = 1'b1; w_data_1 = 16'd51; w_data_2 = 16'd52;
    tick();
    w_valid = 1'b0;
    total++; if (sys_accept_w_1 !== 1'b1 || sys_weight_in_11 !== 16'd51) begin bad++; $display("FAIL rm_beat got=%0b %0d exp=1 51", sys_accept_w_1, sys_weight_in_11); end
    rst = 1'b1;
    #1;
    total++; if (sys_accept_w_1 !== 1'b0 || sys_weight_in_11 !== 16'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 || w_ready !== 1'b0) begin bad++; $display("FAIL rm_async got=acc%0b w%0d busy%0b rdy%0b wr%0b exp=acc0 w0 busy0 rdy1 wr0", sys_accept_w_1, sys_weight_in_11, busy, cmd_ready, w_ready); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++; if (cmd_ready !== 1'b1 || done_seen != d0) begin bad++; $display("FAIL rm_nodone got=rdy%0b n%0d exp=rdy1 n%0d", cmd_ready, done_seen, d0); end
    issue_cmd(16'd1, 2'd1, 1'b0);
    load_w(16'd61, 16'd0, 16'd62, 16'd0);
    total++; if (sys_weight_in_11 !== 16'd62) begin bad++; $display("FAIL rm_reload got=%0d exp=62", sys_weight_in_11); end
    tick();
    x_valid = 1'b1; x_data_1 = 16'd5; x_data_2 = 16'd6;
    tick();
    x_valid = 1'b0;
    total++; if (sys_data_in_11 !== 16'd5) begin bad++; $display("FAIL rm_x got=%0d exp=5", sys_data_in_11); end
    sys_valid_out_21 = 1'b1;
    tick();
    sys_valid_out_21 = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rm_done got=%0b exp=1", done); end
    tick();
  endtask

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    issue_cmd(16'd1, 2'd1, 1'b1);
    tick();
    x_valid = 1'b1; x_data_1 = 16'd1; x_data_2 = 16'd2;
    tick();
    x_valid = 1'b0;
    repeat (7) tick();
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL to_early got=done%0b err%0b exp=done0 err0", done, err); end
    tick();
    total++; if (done !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL to_fire got=done%0b err%0b exp=done1 err1", done, err); end
    tick();
    total++; if (done !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL to_hold got=done%0b err%0b exp=done0 err1", done, err); end
    issue_cmd(16'd0, 2'd1, 1'b1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b exp=0", err); end
    tick();
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rows = '0; cmd_cols = '0; cmd_skip_w = 1'b0;
    w_valid = 1'b0; w_data_1 = '0; w_data_2 = '0;
    x_valid = 1'b0; x_data_1 = '0; x_data_2 = '0;
    sys_valid_out_21 = 1'b0; sys_valid_out_22 = 1'b0;
    #2;
    test_reset();
    test_full_job();
    test_cols1();
    test_stall();
    test_skip_w();
    test_zero_rows();
    test_reset_mid();
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
